alu_mc: RTL and testbench

Parametrised, registered Hack-compatible ALU with a valid/ready handshake and an optional iterative multiplier. It executes the six-bit Hack control encoding (zx, nx, zy, ny, f, no) at any data width with one-cycle latency and full throughput. When the multiplier is compiled in, it also computes WIDTH-bit products over WIDTH cycles. It sits between the CPU decode stage and the D/A/M writeback path and replaces the purely combinational 16-bit ALU in pipelined CPU variants.

---
 rtl/alu_mc.sv | 147 ++++++++++++++
 tb/tb_alu_mc.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - registered Hack ALU with valid/ready handshake; optional shift-add multiplier under ALU_MC_MUL_EN
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] x1, x2, y1, y2, r, hack_out;
  logic [WIDTH:0]   sum;
  logic             hack_cout, hack_ovf;

  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, valid_q, valid_d;
  logic             idle, accept, consume;

  always_comb begin
    x1        = ctrl[5] ? '0 : x;
    x2        = ctrl[4] ? ~x1 : x1;
    y1        = ctrl[3] ? '0 : y;
    y2        = ctrl[2] ? ~y1 : y1;
    sum       = {1'b0, x2} + {1'b0, y2};
    r         = ctrl[1] ? sum[WIDTH-1:0] : (x2 & y2);
    hack_out  = ctrl[0] ? ~r : r;
    hack_cout = ctrl[1] & sum[WIDTH];
    hack_ovf  = ctrl[1] & (x2[WIDTH-1] == y2[WIDTH-1]) & (sum[WIDTH-1] != x2[WIDTH-1]);
  end

`ifdef ALU_MC_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;
  localparam int CW = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  assign idle = (state_q == IDLE);
`else
  logic unused_mul;
  assign unused_mul = mul;
  assign idle       = 1'b1;
`endif

  assign in_ready = idle && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = valid_q && out_ready;

  always_comb begin
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
`ifdef ALU_MC_MUL_EN
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
`endif
    if (consume) valid_d = 1'b0;
    if (accept) begin
`ifdef ALU_MC_MUL_EN
      if (mul) begin
        state_d  = MUL;
        cnt_d    = '0;
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, x};
        mplier_d = y;
      end else begin
`else
      begin
`endif
        out_d   = hack_out;
        cout_d  = hack_cout;
        ovf_d   = hack_ovf;
        valid_d = 1'b1;
      end
    end
`ifdef ALU_MC_MUL_EN
    else if (state_q == MUL) begin
      // one LSB-first partial product per cycle; the last step publishes the result directly
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = IDLE;
        out_d   = acc_step[WIDTH-1:0];
        ovf_d   = |acc_step[2*WIDTH-1:WIDTH];
        cout_d  = 1'b0;
        valid_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef ALU_MC_MUL_EN
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
`ifdef ALU_MC_MUL_EN
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zr        = (out_q == '0);
  assign ng        = out_q[WIDTH-1];

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - randomized and directed bench for alu_mc against an arithmetic reference model
module tb_alu_mc;
  localparam int W = 16;
`ifdef ALU_MC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, mul, out_valid, out_ready, zr, ng, cout, ovf;
  logic [W-1:0] x, y, out;
  logic [5:0]   ctrl;

  int n_checks = 0;
  int n_pass   = 0;

  int m_busy, m_out, p_out;
  bit m_valid, m_cout, m_ovf, p_ovf;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .ctrl(ctrl), .mul(mul), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .zr(zr), .ng(ng), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic void hack_ref(input int xi, input int yi, input logic [5:0] c,
                                   output int o, output bit co, output bit ov);
    int xv, yv, s, rr, sx, sy, ss;
    xv = c[5] ? 0 : xi;
    if (c[4]) xv = 65535 - xv;
    yv = c[3] ? 0 : yi;
    if (c[2]) yv = 65535 - yv;
    s  = xv + yv;
    rr = c[1] ? s % 65536 : (xv & yv);
    o  = c[0] ? 65535 - rr : rr;
    co = c[1] && (s >= 65536);
    sx = (xv >= 32768) ? xv - 65536 : xv;
    sy = (yv >= 32768) ? yv - 65536 : yv;
    ss = sx + sy;
    ov = c[1] && (ss > 32767 || ss < -32768);
  endfunction

  task automatic cycle(input bit iv, input int xi, input int yi, input logic [5:0] c,
                       input bit m, input bit ordy);
    bit     m_rdy, acc, co, ov;
    int     o;
    longint p;
    in_valid  = iv;
    x         = 16'(xi);
    y         = 16'(yi);
    ctrl      = c;
    mul       = m;
    out_ready = ordy;
    #1;
    m_rdy = (m_busy == 0) && (!m_valid || ordy);
    check("in_ready", in_ready, m_rdy);
    acc = iv && m_rdy;
    @(posedge clk);
    if (acc) begin
      if (MUL_EN && m) begin
        p       = longint'(xi) * longint'(yi);
        p_out   = int'(p % 65536);
        p_ovf   = (p >= 65536);
        m_busy  = W;
        m_valid = 1'b0;
      end else begin
        hack_ref(xi, yi, c, o, co, ov);
        m_out   = o;
        m_cout  = co;
        m_ovf   = ov;
        m_valid = 1'b1;
      end
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_valid = 1'b1;
        m_out   = p_out;
        m_ovf   = p_ovf;
        m_cout  = 1'b0;
      end
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    #1;
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out", out, m_out);
      check("zr", zr, m_out == 0);
      check("ng", ng, m_out >= 32768);
      check("cout", cout, m_cout);
      check("ovf", ovf, m_ovf);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    mul       = 1'b0;
    x         = 16'h0001;
    y         = 16'h0001;
    ctrl      = 6'b000010;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_busy  = 0;
    m_valid = 1'b0;
    m_out   = 0;
    m_cout  = 1'b0;
    m_ovf   = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, 16'h0000);
    check("rst_zr", zr, 1'b1);
    check("rst_ng", ng, 1'b0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
  endtask

  function automatic int pick_operand();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 65535;
      2: return 32767;
      3: return 32768;
      default: return int'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; mul = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; ctrl = '0;
    do_reset();

    cycle(1, 5, 3, 6'b000010, 0, 1);
    check("tp_add", {out, zr, ng, cout, ovf}, {16'h0008, 4'b0000});
    cycle(1, 3, 5, 6'b010011, 0, 1);
    check("tp_sub", {out, ng, cout, ovf}, {16'hFFFE, 3'b110});
    cycle(1, 3, 5, 6'b101010, 0, 1);
    check("tp_zero", {out, zr}, {16'h0000, 1'b1});
    cycle(1, 16'h7FFF, 1, 6'b000010, 0, 1);
    check("tp_ovf", {out, ng, cout, ovf}, {16'h8000, 3'b101});

    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 6'b000010, 0, 0);
    check("tp_hold", out, 16'h8000);
    cycle(1, 1, 1, 6'b000010, 0, 1);
    check("tp_release", out, 16'h0002);

    cycle(1, 16'h0123, 16'h0010, 6'b000010, 1, 1);
    for (int i = 0; i < W; i++) cycle(0, 0, 0, 6'b000000, 0, 0);
    check("tp_mul", {out, ovf}, {(MUL_EN ? 16'h1230 : 16'h0133), 1'b0});
    cycle(1, 16'h0100, 16'h0100, 6'b000010, 1, 1);
    for (int i = 0; i < W; i++) cycle(0, 0, 0, 6'b000000, 0, 0);
    check("tp_mul_ovf", {out, zr, ovf},
          MUL_EN ? {16'h0000, 2'b11} : {16'h0200, 2'b00});

    cycle(1, 16'h0123, 16'h0010, 6'b000010, 1, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 6'b000000, 0, 1);
    do_reset();
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 6'b000000, 0, $urandom_range(0, 1));
    cycle(1, 5, 3, 6'b000010, 0, 1);
    check("tp_after_reset", out, 16'h0008);

    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, pick_operand(), pick_operand(),
            6'($urandom_range(0, 63)), $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) != 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
